// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// mult/div run for a fixed latency, then commit to HI/LO with a one-cycle done pulse.
module mult_div_unit #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       MDop,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned CW  = 8;
   localparam int unsigned PW  = 2 * WIDTH;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [CW-1:0]    n_cyc;
   logic [PW-1:0]    prod_s, prod_u;
   logic [WIDTH-1:0] dvs_s, dvs_u;
   logic [WIDTH-1:0] quo_s, rem_s, quo_u, rem_u;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic             div_ovf;
   logic             div_zero;

   // Result datapath, evaluated from the operands latched at acceptance.
   always_comb begin
      prod_s   = PW'($signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q}));
      prod_u   = PW'({{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q});
      div_zero = (b_q == '0);
      div_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
      // Divide by one for the zero and overflow cases: keeps X out and yields MIN/0 on overflow.
      dvs_s    = (div_zero || div_ovf) ? WIDTH'(1) : b_q;
      dvs_u    = div_zero ? WIDTH'(1) : b_q;
      quo_s    = WIDTH'($signed(a_q) / $signed(dvs_s));
      rem_s    = WIDTH'($signed(a_q) % $signed(dvs_s));
      quo_u    = a_q / dvs_u;
      rem_u    = a_q % dvs_u;
      res_hi   = hi_q;
      res_lo   = lo_q;
      case (op_q)
         2'b00: begin res_hi = prod_s[PW-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
         2'b01: begin res_hi = prod_u[PW-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
         2'b10: begin res_hi = rem_s;              res_lo = quo_s;              end
         default: begin res_hi = rem_u;            res_lo = quo_u;              end
      endcase
   end

   assign n_cyc = op_q[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

   // Next-state and register updates.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (MDop)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     state_d = S_RUN;
                     cnt_d   = CW'(1);
                     op_d    = MDop[1:0];
                     a_d     = srcA;
                     b_d     = srcB;
                  end
                  OP_MTHI: hi_d = srcA;
                  OP_MTLO: lo_d = srcA;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (cnt_q == n_cyc) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               // A zero divisor completes the timing but leaves HI/LO untouched.
               if (!(op_q[1] && div_zero)) begin
                  hi_d = res_hi;
                  lo_d = res_lo;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  MDop;
   logic [31:0] srcA, srcB;
   logic        busy, done;
   logic [31:0] HI, LO;

   int checks   = 0;
   int failures = 0;
   logic [31:0] m_hi, m_lo;

   mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .MDop(MDop),
      .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result {HI,LO} computed directly from the arithmetic definitions.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] hi, input logic [31:0] lo);
      longint          ps;
      longint unsigned pu;
      int              sa, sb, q, r;
      case (op)
         3'd0: begin ps = longint'($signed(a)) * longint'($signed(b)); return 64'(ps); end
         3'd1: begin pu = {32'd0, a} * {32'd0, b}; return pu; end
         3'd2: begin
            if (b == 32'd0) return {hi, lo};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = a; sb = b; q = sa / sb; r = sa % sb;
            return {32'(r), 32'(q)};
         end
         default: begin
            if (b == 32'd0) return {hi, lo};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Issue a mult/div at the current sample point and follow it to the done cycle.
   task automatic run_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input bit poke);
      logic [63:0] exp;
      int n;
      exp = model(op, a, b, m_hi, m_lo);
      n = op[1] ? 10 : 5;
      start = 1'b1; MDop = op; srcA = a; srcB = b;
      @(negedge clk);
      start = 1'b0; srcA = $urandom; srcB = $urandom; MDop = 3'($urandom_range(0, 7));
      for (int k = 1; k <= n; k++) begin
         check("busy_run", 32'(busy), 32'd1);
         check("done_run", 32'(done), 32'd0);
         check("hi_hold", HI, m_hi);
         check("lo_hold", LO, m_lo);
         // An mtlo presented while busy must be dropped.
         if (poke && k == 2) begin start = 1'b1; MDop = 3'b101; srcA = 32'h1234; end
         else start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      check("busy_end", 32'(busy), 32'd0);
      check("done_end", 32'(done), 32'd1);
      check("hi_res", HI, m_hi);
      check("lo_res", LO, m_lo);
   endtask

   task automatic run_move(input logic [2:0] op, input logic [31:0] a);
      start = 1'b1; MDop = op; srcA = a; srcB = $urandom;
      @(negedge clk);
      start = 1'b0;
      if (op == 3'b100) m_hi = a;
      if (op == 3'b101) m_lo = a;
      check("mv_hi", HI, m_hi);
      check("mv_lo", LO, m_lo);
      check("mv_busy", 32'(busy), 32'd0);
      check("mv_done", 32'(done), 32'd0);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;

      // Reset with a simultaneous start that must be ignored.
      reset = 1'b1; start = 1'b1; MDop = 3'b100; srcA = 32'hDEAD_BEEF; srcB = '0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0; start = 1'b0;
      m_hi = '0; m_lo = '0;
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      check("rst_hi2", HI, 32'd0);

      run_muldiv(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b0);
      check("mult_neg_hi", HI, 32'hFFFF_FFFF);
      check("mult_neg_lo", LO, 32'hFFFF_FFFA);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);

      run_muldiv(3'b001, 32'hFFFF_FFFF, 32'd2, 1'b0);
      check("multu_hi", HI, 32'h1);
      check("multu_lo", LO, 32'hFFFF_FFFE);
      run_muldiv(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_neg_lo", LO, 32'hFFFF_FFFD);
      check("div_neg_hi", HI, 32'hFFFF_FFFF);
      run_muldiv(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf_lo", LO, 32'h8000_0000);
      check("div_ovf_hi", HI, 32'h0);

      run_move(3'b100, 32'h11);
      run_move(3'b101, 32'h22);
      run_muldiv(3'b011, 32'd100, 32'd0, 1'b0);
      check("divz_hi", HI, 32'h11);
      check("divz_lo", LO, 32'h22);

      run_muldiv(3'b011, 32'd1000, 32'd7, 1'b1);
      @(negedge clk);
      run_move(3'b100, 32'hABCD);
      check("mthi_val", HI, 32'hABCD);
      run_move(3'b110, 32'h5555_5555);
      run_move(3'b111, 32'hAAAA_AAAA);

      // Reset in the third busy cycle of a div discards it.
      start = 1'b1; MDop = 3'b010; srcA = 32'd77; srcB = 32'd5;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         check("pre_rst_busy", 32'(busy), 32'd1);
         if (k < 3) @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      for (int k = 0; k < 12; k++) begin
         check("rrun_busy", 32'(busy), 32'd0);
         check("rrun_done", 32'(done), 32'd0);
         check("rrun_hi", HI, 32'd0);
         check("rrun_lo", LO, 32'd0);
         @(negedge clk);
      end

      // Back-to-back: the second start lands in the done cycle of the first.
      run_muldiv(3'b000, 32'd12345, 32'hFFFF_FF00, 1'b0);
      run_muldiv(3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 5));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = '0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 20));
            3: b = 32'hFFFF_FFFF;
            default: ;
         endcase
         if (op >= 3'd4) run_move(op, a);
         else run_muldiv(op, a, b, ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
